// File: rtl/decode_stage_r32i_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU codes and the control bundle
// that travels from decode to execute.
package r32i_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPPI   = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPPR   = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h8;
    localparam logic [3:0] ALU_CPY = 4'hF;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2,
        MEM_RSVD = 2'd3
    } mem_size_t;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_write;
        logic        link_write;
        logic        test_branch;
        logic        always_branch;
        logic        use_imm;
        logic        use_pc;
        logic [2:0]  branch_type;
        logic [3:0]  alu_code;
        logic [31:0] imm;
        logic        mem_read;
        logic        mem_write;
        mem_size_t   mem_size;
        logic        mem_unsigned;
        logic        illegal;
    } decode_bundle_t;

endpackage

// File: rtl/decode_comb_r32i.sv
// Pure combinational RV32I decoder: instruction word -> control bundle.
// Illegal encodings keep their fields but lose every write/branch/memory enable.
module decode_comb_r32i
    import r32i_pkg::*;
(
    input  logic [31:0]    i_raw_ins,
    output decode_bundle_t o_bundle
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;

    assign w_opcode = i_raw_ins[6:0];
    assign w_funct3 = i_raw_ins[14:12];
    assign w_funct7 = i_raw_ins[31:25];

    assign w_imm_i = {{20{i_raw_ins[31]}}, i_raw_ins[31:20]};
    assign w_imm_s = {{20{i_raw_ins[31]}}, i_raw_ins[31:25], i_raw_ins[11:7]};
    assign w_imm_b = {{19{i_raw_ins[31]}}, i_raw_ins[31], i_raw_ins[7],
                      i_raw_ins[30:25], i_raw_ins[11:8], 1'b0};
    assign w_imm_u = {i_raw_ins[31:12], 12'd0};
    assign w_imm_j = {{11{i_raw_ins[31]}}, i_raw_ins[31], i_raw_ins[19:12],
                      i_raw_ins[20], i_raw_ins[30:21], 1'b0};

    always_comb begin
        o_bundle     = '0;
        o_bundle.rs1 = i_raw_ins[19:15];
        o_bundle.rs2 = i_raw_ins[24:20];
        o_bundle.rd  = i_raw_ins[11:7];
        case (w_opcode)
            OP_OPPI: begin
                o_bundle.alu_code  = (w_funct3 == 3'd5) ? {i_raw_ins[30], w_funct3} : {1'b0, w_funct3};
                o_bundle.use_imm   = 1'b1;
                o_bundle.reg_write = 1'b1;
                o_bundle.imm       = w_imm_i;
                o_bundle.illegal   = ((w_funct3 == 3'd1) && (w_funct7 != 7'h00)) ||
                                     ((w_funct3 == 3'd5) && (w_funct7 != 7'h00) && (w_funct7 != 7'h20));
            end
            OP_OPPR: begin
                o_bundle.alu_code  = {i_raw_ins[30], w_funct3};
                o_bundle.reg_write = 1'b1;
                o_bundle.illegal   = ((w_funct7 != 7'h00) && (w_funct7 != 7'h20)) ||
                                     ((w_funct7 == 7'h20) && (w_funct3 != 3'd0) && (w_funct3 != 3'd5));
            end
            OP_LUI: begin
                o_bundle.alu_code  = ALU_CPY;
                o_bundle.use_imm   = 1'b1;
                o_bundle.reg_write = 1'b1;
                o_bundle.imm       = w_imm_u;
            end
            OP_AUIPC: begin
                o_bundle.alu_code  = ALU_ADD;
                o_bundle.use_imm   = 1'b1;
                o_bundle.use_pc    = 1'b1;
                o_bundle.reg_write = 1'b1;
                o_bundle.imm       = w_imm_u;
            end
            OP_JAL, OP_JALR: begin
                // The link value is written through link_write, not reg_write.
                o_bundle.alu_code      = (w_opcode == OP_JAL) ? ALU_CPY : ALU_ADD;
                o_bundle.use_imm       = 1'b1;
                o_bundle.always_branch = 1'b1;
                o_bundle.link_write    = 1'b1;
                o_bundle.imm           = (w_opcode == OP_JAL) ? w_imm_j : w_imm_i;
            end
            OP_BRANCH: begin
                o_bundle.alu_code    = ALU_ADD;
                o_bundle.test_branch = 1'b1;
                o_bundle.use_pc      = 1'b1;
                o_bundle.use_imm     = 1'b1;
                o_bundle.branch_type = w_funct3;
                o_bundle.imm         = w_imm_b;
                o_bundle.illegal     = (w_funct3 == 3'd2) || (w_funct3 == 3'd3);
            end
            OP_LOAD: begin
                o_bundle.alu_code     = ALU_ADD;
                o_bundle.mem_read     = 1'b1;
                o_bundle.use_imm      = 1'b1;
                o_bundle.reg_write    = 1'b1;
                o_bundle.imm          = w_imm_i;
                o_bundle.mem_size     = mem_size_t'(w_funct3[1:0]);
                o_bundle.mem_unsigned = w_funct3[2];
                o_bundle.illegal      = (w_funct3 == 3'd3) || (w_funct3 == 3'd6) || (w_funct3 == 3'd7);
            end
            OP_STORE: begin
                o_bundle.alu_code  = ALU_ADD;
                o_bundle.mem_write = 1'b1;
                o_bundle.use_imm   = 1'b1;
                o_bundle.imm       = w_imm_s;
                o_bundle.mem_size  = mem_size_t'(w_funct3[1:0]);
                o_bundle.illegal   = (w_funct3 > 3'd2);
            end
            default: o_bundle.illegal = 1'b1;
        endcase
        if (o_bundle.rd == 5'd0) o_bundle.reg_write = 1'b0;
        if (o_bundle.illegal) begin
            o_bundle.reg_write     = 1'b0;
            o_bundle.link_write    = 1'b0;
            o_bundle.test_branch   = 1'b0;
            o_bundle.always_branch = 1'b0;
            o_bundle.mem_read      = 1'b0;
            o_bundle.mem_write     = 1'b0;
        end
    end

endmodule

// File: rtl/decode_stage_r32i.sv
// Registered RV32I decode stage: output register plus optional skid entry,
// valid/ready on both sides, flush drops everything held and incoming.
module decode_stage_r32i
    import r32i_pkg::*;
#(
    parameter  int dataW      = 32,
    parameter  bit SkidEnable = 1'b1,
    localparam int RegAddrW   = $clog2(dataW)
) (
    input  logic                clk,
    input  logic                nReset,
    input  logic                flush,
    input  logic                inValid,
    output logic                inReady,
    input  logic [31:0]         rawIns,
    input  logic [dataW-1:0]    PCIn,
    output logic                outValid,
    input  logic                outReady,
    output logic [dataW-1:0]    PCOut,
    output logic [RegAddrW-1:0] RegData1,
    output logic [RegAddrW-1:0] RegData2,
    output logic [RegAddrW-1:0] RegWriteAddr,
    output logic                RegWriteControl,
    output logic                LinkAddrWrite,
    output logic                TestBranch,
    output logic                AlwaysBranch,
    output logic                UseImm,
    output logic                UsePC,
    output logic [2:0]          BranchType,
    output logic [3:0]          ALUCode,
    output logic [dataW-1:0]    ImmOut,
    output logic                MemRead,
    output logic                MemWrite,
    output logic [1:0]          MemSize,
    output logic                MemUnsigned,
    output logic                Illegal
);

    // Handshake: a side transfers on a cycle where its valid and ready are both high.
    decode_bundle_t   w_dec;
    decode_bundle_t   r_out;
    decode_bundle_t   r_skid;
    logic [dataW-1:0] r_out_pc;
    logic [dataW-1:0] r_skid_pc;
    logic             r_out_valid;
    logic             r_skid_valid;
    logic             w_out_free;
    logic             w_in_ready;
    logic             w_in_fire;

    decode_comb_r32i u_decode (
        .i_raw_ins (rawIns),
        .o_bundle  (w_dec)
    );

    assign w_out_free = ~r_out_valid | outReady;
    // r_skid_valid is a flop, so the skid-mode ready has no path from outReady.
    assign w_in_ready = SkidEnable ? ~r_skid_valid : w_out_free;
    assign w_in_fire  = inValid & w_in_ready;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out        <= '0;
            r_skid       <= '0;
            r_out_pc     <= '0;
            r_skid_pc    <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_pc     <= r_skid_pc;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= w_in_fire;
                if (w_in_fire) begin
                    r_out    <= w_dec;
                    r_out_pc <= PCIn;
                end
            end
        end else if (w_in_fire) begin
            r_skid       <= w_dec;
            r_skid_pc    <= PCIn;
            r_skid_valid <= 1'b1;
        end
    end

    assign inReady         = w_in_ready;
    assign outValid        = r_out_valid;
    assign PCOut           = r_out_pc;
    assign RegData1        = RegAddrW'(r_out.rs1);
    assign RegData2        = RegAddrW'(r_out.rs2);
    assign RegWriteAddr    = RegAddrW'(r_out.rd);
    assign RegWriteControl = r_out.reg_write;
    assign LinkAddrWrite   = r_out.link_write;
    assign TestBranch      = r_out.test_branch;
    assign AlwaysBranch    = r_out.always_branch;
    assign UseImm          = r_out.use_imm;
    assign UsePC           = r_out.use_pc;
    assign BranchType      = r_out.branch_type;
    assign ALUCode         = r_out.alu_code;
    assign ImmOut          = dataW'($signed(r_out.imm));
    assign MemRead         = r_out.mem_read;
    assign MemWrite        = r_out.mem_write;
    assign MemSize         = r_out.mem_size;
    assign MemUnsigned     = r_out.mem_unsigned;
    assign Illegal         = r_out.illegal;

endmodule

// File: tb/tb_decode_stage_r32i.sv
// Bench for decode_stage_r32i: directed decodes, random stream under
// backpressure, flush and asynchronous reset, against a queue-based model.
module tb_decode_stage_r32i;

    localparam int BW = 98;

    logic        clk = 1'b0;
    logic        nReset, flush, inValid, outReady;
    logic        inReady, outValid;
    logic [31:0] rawIns, PCIn, PCOut, ImmOut;
    logic [4:0]  RegData1, RegData2, RegWriteAddr;
    logic        RegWriteControl, LinkAddrWrite, TestBranch, AlwaysBranch, UseImm, UsePC;
    logic [2:0]  BranchType;
    logic [3:0]  ALUCode;
    logic        MemRead, MemWrite, MemUnsigned, Illegal;
    logic [1:0]  MemSize;
    logic [BW-1:0] w_obs;

    int errors = 0;
    int checks = 0;
    logic [BW-1:0] exp_q[$];

    always #5 clk = ~clk;

    decode_stage_r32i dut (
        .clk(clk), .nReset(nReset), .flush(flush), .inValid(inValid), .inReady(inReady),
        .rawIns(rawIns), .PCIn(PCIn), .outValid(outValid), .outReady(outReady), .PCOut(PCOut),
        .RegData1(RegData1), .RegData2(RegData2), .RegWriteAddr(RegWriteAddr),
        .RegWriteControl(RegWriteControl), .LinkAddrWrite(LinkAddrWrite), .TestBranch(TestBranch),
        .AlwaysBranch(AlwaysBranch), .UseImm(UseImm), .UsePC(UsePC), .BranchType(BranchType),
        .ALUCode(ALUCode), .ImmOut(ImmOut), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemSize(MemSize), .MemUnsigned(MemUnsigned), .Illegal(Illegal)
    );

    assign w_obs = {PCOut, RegData1, RegData2, RegWriteAddr, RegWriteControl, LinkAddrWrite,
                    TestBranch, AlwaysBranch, UseImm, UsePC, BranchType, ALUCode, ImmOut,
                    MemRead, MemWrite, MemSize, MemUnsigned, Illegal};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode written straight from the instruction-set rules.
    function automatic logic [BW-1:0] ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        int op = int'(ins[6:0]);
        int f3 = int'(ins[14:12]);
        int f7 = int'(ins[31:25]);
        logic rw = 0, lw = 0, tbr = 0, ab = 0, ui = 0, up = 0, mr = 0, mw = 0, mu = 0, ill = 0;
        logic [2:0] bt = 0;
        logic [3:0] alu = 0;
        logic [1:0] ms = 0;
        int imm = 0;
        int imm_i = $signed(ins) >>> 20;
        int imm_s = ((($signed(ins) >>> 25)) * 32) + int'(ins[11:7]);
        int imm_b = ($signed(ins) >>> 31) * 4096 + int'(ins[7]) * 2048
                    + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        int imm_u = int'(ins & 32'hFFFF_F000);
        int imm_j = ($signed(ins) >>> 31) * 1048576 + int'(ins[19:12]) * 4096
                    + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
        case (op)
            'h13: begin
                alu = (f3 == 5) ? 4'(f3 + 8 * int'(ins[30])) : 4'(f3);
                ui = 1; rw = 1; imm = imm_i;
                ill = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 'h20);
            end
            'h33: begin
                alu = 4'(f3 + 8 * int'(ins[30])); rw = 1;
                ill = (f7 != 0 && f7 != 'h20) || (f7 == 'h20 && f3 != 0 && f3 != 5);
            end
            'h37: begin alu = 4'hF; ui = 1; rw = 1; imm = imm_u; end
            'h17: begin alu = 4'h0; ui = 1; up = 1; rw = 1; imm = imm_u; end
            'h6F: begin alu = 4'hF; ui = 1; ab = 1; lw = 1; imm = imm_j; end
            'h67: begin alu = 4'h0; ui = 1; ab = 1; lw = 1; imm = imm_i; end
            'h63: begin
                alu = 4'h0; tbr = 1; up = 1; ui = 1; bt = 3'(f3); imm = imm_b;
                ill = (f3 == 2 || f3 == 3);
            end
            'h03: begin
                alu = 4'h0; mr = 1; ui = 1; rw = 1; imm = imm_i;
                ms = 2'(f3 % 4); mu = (f3 >= 4);
                ill = (f3 == 3 || f3 >= 6);
            end
            'h23: begin
                alu = 4'h0; mw = 1; ui = 1; imm = imm_s; ms = 2'(f3 % 4);
                ill = (f3 > 2);
            end
            default: ill = 1;
        endcase
        if (ins[11:7] == 0) rw = 0;
        if (ill) begin rw = 0; lw = 0; tbr = 0; ab = 0; mr = 0; mw = 0; end
        return {pc, ins[19:15], ins[24:20], ins[11:7], rw, lw, tbr, ab, ui, up, bt, alu,
                32'(imm), mr, mw, ms, mu, ill};
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [6:0]  ops [10] = '{7'h13, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h7F};
        logic [31:0] r = $urandom;
        r[6:0] = ops[$urandom_range(0, 9)];
        if ($urandom_range(0, 2) != 0) r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return r;
    endfunction

    // One clock: handshake checks and model update mid-cycle, then advance.
    task automatic cycle();
        logic [BW-1:0] e;
        @(negedge clk);
        if (nReset) begin
            chk("out_valid", outValid, exp_q.size() > 0);
            chk("in_ready", inReady, exp_q.size() < 2);
            if (flush) begin
                exp_q.delete();
            end else begin
                if (outValid && outReady && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("bundle", w_obs, e);
                end
                if (inValid && inReady) exp_q.push_back(ref_decode(rawIns, PCIn));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] ins, input logic [31:0] pc);
        rawIns = ins; PCIn = pc; inValid = 1'b1; outReady = 1'b1;
        cycle();
        inValid = 1'b0;
    endtask

    initial begin
        int k = 0;
        logic [31:0] pc = 32'h1000;
        logic acc;
        int guard;
        nReset = 1'b0; flush = 1'b0; inValid = 1'b0; outReady = 1'b0; rawIns = '0; PCIn = '0;
        #12;
        chk("rst_out_valid", outValid, 0);
        chk("rst_in_ready", inReady, 1);
        chk("rst_imm", ImmOut, 0);
        chk("rst_alu", ALUCode, 0);
        @(posedge clk); #1;
        nReset = 1'b1;
        cycle();

        present(32'h00500093, 32'h100);
        chk("addi_valid", outValid, 1); chk("addi_alu", ALUCode, 0); chk("addi_imm", ImmOut, 5);
        chk("addi_rd", RegWriteAddr, 1); chk("addi_rw", RegWriteControl, 1); chk("addi_useimm", UseImm, 1);
        cycle();
        present(32'h402081B3, 32'h104);
        chk("sub_alu", ALUCode, 8); chk("sub_rs1", RegData1, 1); chk("sub_rs2", RegData2, 2);
        chk("sub_useimm", UseImm, 0); chk("sub_illegal", Illegal, 0);
        cycle();
        present(32'h40208033, 32'h108);
        chk("sub_x0_rw", RegWriteControl, 0);
        cycle();
        present(32'h00812283, 32'h10C);
        chk("lw_read", MemRead, 1); chk("lw_size", MemSize, 2); chk("lw_imm", ImmOut, 8);
        cycle();
        present(32'hFE512E23, 32'h110);
        chk("sw_write", MemWrite, 1); chk("sw_imm", ImmOut, 32'hFFFFFFFC); chk("sw_rw", RegWriteControl, 0);
        cycle();
        present(32'hFFFFFFFF, 32'h114);
        chk("ill_flag", Illegal, 1); chk("ill_valid", outValid, 1);
        chk("ill_enables", {RegWriteControl, LinkAddrWrite, TestBranch, AlwaysBranch, MemRead, MemWrite}, 0);
        cycle();

        // Random stream with outReady held low 3 of every 7 cycles.
        for (int n = 0; n < 24; n++) begin
            rawIns = rand_ins(); PCIn = pc; pc += 4;
            inValid = ($urandom_range(0, 4) != 0);
            if (!inValid) begin outReady = 1'b1; cycle(); k++; inValid = 1'b1; end
            acc = 1'b0; guard = 0;
            while (!acc && guard < 20) begin
                outReady = (k % 7 < 3) ? 1'b0 : 1'($urandom_range(0, 1));
                acc = inReady;
                cycle(); k++; guard++;
            end
            checks++;
            assert (acc) else begin errors++; $error("FAIL accept_timeout observed=%0d expected=1", acc); end
        end
        inValid = 1'b0; outReady = 1'b1;
        repeat (4) cycle();

        // Flush with output and skid both full and a new input presented.
        outReady = 1'b0;
        rawIns = 32'h00A00113; PCIn = 32'h2000; inValid = 1'b1; cycle();
        rawIns = 32'h00B00193; PCIn = 32'h2004; cycle();
        chk("full_in_ready", inReady, 0);
        rawIns = 32'h00C00213; PCIn = 32'h2008; flush = 1'b1; cycle();
        flush = 1'b0; inValid = 1'b0;
        chk("flush_out_valid", outValid, 0);
        chk("flush_in_ready", inReady, 1);
        present(32'h00D00293, 32'h3000);
        chk("post_flush_pc", PCOut, 32'h3000);
        cycle();

        // Asynchronous reset while bundles are held.
        outReady = 1'b0;
        rawIns = 32'h00812283; PCIn = 32'h4000; inValid = 1'b1; cycle();
        rawIns = 32'h402081B3; PCIn = 32'h4004; cycle();
        inValid = 1'b0;
        #1 nReset = 1'b0;
        #1;
        chk("arst_out_valid", outValid, 0);
        chk("arst_in_ready", inReady, 1);
        chk("arst_pc", PCOut, 0);
        chk("arst_memread", MemRead, 0);
        exp_q.delete();
        @(posedge clk); #1;
        nReset = 1'b1;
        present(32'h00500093, 32'h5000);
        cycle();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_stage_r32i.md
Name: decode_stage_r32i

Overview:
Registered, handshaked RV32I decode stage. It is the successor of the combinational decoder and sits between fetch and execute. It decodes one instruction per cycle into a registered control bundle and adds LOAD/STORE memory control and illegal-instruction detection. A skid buffer provides valid/ready backpressure, and a flush input supports branch redirects.

Parameters:
dataW, 32, datapath and immediate width (>=32; immediates sign-extend to dataW)
SkidEnable, 1, 1 = two-entry skid buffer with registered inReady; 0 = single register, inReady = outReady | ~outValid
RegAddrW, $clog2(dataW), register address width (localparam, not overridable)

Ports:
clk  in  1  single clock
nReset  in  1  reset; asynchronous, active-low
flush  in  1  discard all held and incoming instructions
inValid  in  1  fetch presents rawIns/PCIn
inReady  out  1  stage accepts this cycle
rawIns  in  32  instruction word
PCIn  in  dataW  address of rawIns
outValid  out  1  bundle valid
outReady  in  1  execute consumes bundle
PCOut  out  dataW  PC of the decoded instruction
RegData1, RegData2, RegWriteAddr  out  RegAddrW  rs1, rs2, rd
RegWriteControl, LinkAddrWrite, TestBranch, AlwaysBranch, UseImm, UsePC  out  1  same meanings as existing decoder
BranchType  out  3  funct3 of branches
ALUCode  out  4  ALU operation
ImmOut  out  dataW  decoded immediate
MemRead, MemWrite  out  1  load/store
MemSize  out  2  0 = byte, 1 = half, 2 = word
MemUnsigned  out  1  LBU/LHU
Illegal  out  1  unsupported encoding

Behaviour:
- Reset (async assert, sync release): outValid=0, all bundle outputs 0, inReady=1, skid empty.
- Transfer in = inValid & inReady. Transfer out = outValid & outReady.
- Latency: exactly 1 cycle from accepted input to outValid when the output register is free.
- Skid buffer (SkidEnable=1):
  - If the input is accepted while the output register is held (outValid & ~outReady), the decoded bundle goes to the skid register.
  - inReady is registered: inReady = ~skidValid.
  - On transfer out with skid full, the skid entry moves to output the same cycle, and inReady rises the next cycle.
- Order is preserved. No bundle is dropped or duplicated under any outReady pattern.
- flush: next cycle, outValid=0, skid empty, inReady=1. The input presented in the flush cycle is dropped. flush has priority over all other transfers.
- Decode rules:
  - OPPI: ALUCode = {ins[30], funct3} for funct3==5, else {0, funct3}. UseImm=1, I-type immediate.
  - OPPR: ALUCode = {ins[30], funct3}.
  - LUI: CPY, U-type immediate. AUIPC: ADD, UsePC.
  - JAL: J-type immediate, CPY. JALR: I-type immediate, ADD. Both set AlwaysBranch and LinkAddrWrite.
  - BRANCH: TestBranch, UsePC, UseImm, ADD, B-type immediate.
- LOAD: MemRead, UseImm, ADD, RegWriteControl, I-type immediate.
  - funct3 0/1/2 -> MemSize 0/1/2, MemUnsigned=0.
  - funct3 4/5 -> MemSize 0/1, MemUnsigned=1.
- STORE: MemWrite, UseImm, ADD, S-type immediate, MemSize = funct3[1:0].
- RegWriteControl is forced 0 when rd==0 (LinkAddrWrite is unaffected).
- Illegal=1 for any of:
  - unknown opcode (FENCE and SYSTEM included);
  - OPPR funct7 not in {0x00, 0x20};
  - funct7=0x20 with funct3 not in {0, 5};
  - OPPI funct3==1 with funct7!=0, or funct3==5 with funct7 not in {0x00, 0x20};
  - LOAD funct3 in {3, 6, 7};
  - STORE funct3 > 2;
  - BRANCH funct3 in {2, 3}.
- An illegal instruction still passes with outValid=1 and Illegal=1, all write, branch and memory enables forced 0.
- Immediates are sign-extended from ins[31] to dataW. The U-type immediate is {ins[31:12], 12'd0}, sign-extended.

Decomposition:
- Package r32i_pkg: opcode constants, ALU codes (ADD=0, SUB=8, CPY), mem_size_t enum, and a packed decode_bundle_t struct holding every bundle field.
- Sub-module decode_comb_r32i: pure combinational rawIns -> decode_bundle_t.
- decode_stage_r32i holds only the handshake, the skid buffer and the flush logic.

Test Plan:
- After reset, with no input: outValid=0 and inReady=1. Then present 0x00500093 (ADDI x1,x0,5) with outReady=1. Next cycle: outValid=1, ALUCode=0, ImmOut=5, RegWriteAddr=1, RegWriteControl=1, UseImm=1.
- 0x402081B3 (SUB x3,x1,x2) -> ALUCode=8, RegData1=1, RegData2=2, UseImm=0, Illegal=0. Same encoding with rd=0 -> RegWriteControl=0.
- 0x00812283 (LW x5,8(x2)) -> MemRead=1, MemSize=2, ImmOut=8. 0xFE512E23 (SW x5,-4(x2)) -> MemWrite=1, ImmOut=0xFFFFFFFC, RegWriteControl=0.
- 0xFFFFFFFF -> Illegal=1, outValid=1, all enables 0.
- Stream 8 instructions with outReady toggling randomly, holding low for 3 cycles. Require: inReady deasserts only when skid is full, and output order/PCOut sequence matches input with no loss or duplication.
- Assert flush while both entries are full and inValid=1. Next cycle: outValid=0 and inReady=1; the flushed instructions never appear. Assert nReset mid-stream: outputs clear immediately, without waiting for a clock edge.
